// File: rtl/transfer_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : transfer_datapath
//  Description : Two small register-file memories with address counters.
//                Memory A is written from DataIn, and its registered read
//                data (DOutA) feeds the write port of memory B. Both reads
//                are registered and write-first. WrCntB counts memory B
//                writes and saturates at the depth of memory B.
//                Optional feature macro: XFER_OVF_EN adds the sticky OvfA
//                output, which flags an AddrA wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module transfer_datapath #(
    parameter int DW  = 8,
    parameter int AWA = 3,
    parameter int AWB = 2
) (
    input  logic           clock,
    input  logic           Reset,
    input  logic           IncA,
    input  logic           IncB,
    input  logic           WEA,
    input  logic           WEB,
    input  logic [DW-1:0]  DataIn,
    output logic [AWA-1:0] AddrA,
    output logic [AWB-1:0] AddrB,
    output logic [DW-1:0]  DOutA,
    output logic [DW-1:0]  DOutB,
`ifdef XFER_OVF_EN
    output logic           OvfA,
`endif
    output logic [AWB:0]   WrCntB
);

    localparam int             DEPTH_A     = 2 ** AWA;
    localparam int             DEPTH_B     = 2 ** AWB;
    localparam logic [AWB:0]   WRCNT_MAX   = (AWB + 1)'(DEPTH_B);
    localparam logic [AWA-1:0] ADDR_A_LAST = {AWA{1'b1}};

    // Storage and pipeline registers
    logic [DW-1:0]  mem_a_q [DEPTH_A];
    logic [DW-1:0]  mem_a_d [DEPTH_A];
    logic [DW-1:0]  mem_b_q [DEPTH_B];
    logic [DW-1:0]  mem_b_d [DEPTH_B];
    logic [AWA-1:0] addr_a_q,   addr_a_d;
    logic [AWB-1:0] addr_b_q,   addr_b_d;
    logic [DW-1:0]  dout_a_q,   dout_a_d;
    logic [DW-1:0]  dout_b_q,   dout_b_d;
    logic [AWB:0]   wr_cnt_b_q, wr_cnt_b_d;

    // Memory A: write at the pre-edge address, advance counter, write-first read
    always_comb begin
        mem_a_d  = mem_a_q;
        if (WEA) begin
            mem_a_d[addr_a_q] = DataIn;
        end
        addr_a_d = IncA ? addr_a_q + 1'b1 : addr_a_q;
        dout_a_d = WEA ? DataIn : mem_a_q[addr_a_q];
    end

    // Memory B: written from the registered A read data (the transfer path)
    always_comb begin
        mem_b_d  = mem_b_q;
        if (WEB) begin
            mem_b_d[addr_b_q] = dout_a_q;
        end
        addr_b_d = IncB ? addr_b_q + 1'b1 : addr_b_q;
        dout_b_d = WEB ? dout_a_q : mem_b_q[addr_b_q];
    end

    // Write counter for memory B, holding once it reaches the memory depth
    always_comb begin
        wr_cnt_b_d = wr_cnt_b_q;
        if (WEB && (wr_cnt_b_q != WRCNT_MAX)) begin
            wr_cnt_b_d = wr_cnt_b_q + 1'b1;
        end
    end

    // State registers; reset clears every memory word as well as the outputs
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH_A; i++) begin
                mem_a_q[i] <= '0;
            end
            for (int j = 0; j < DEPTH_B; j++) begin
                mem_b_q[j] <= '0;
            end
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            dout_a_q   <= '0;
            dout_b_q   <= '0;
            wr_cnt_b_q <= '0;
        end else begin
            mem_a_q    <= mem_a_d;
            mem_b_q    <= mem_b_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            dout_a_q   <= dout_a_d;
            dout_b_q   <= dout_b_d;
            wr_cnt_b_q <= wr_cnt_b_d;
        end
    end

`ifdef XFER_OVF_EN
    logic ovf_a_q, ovf_a_d;

    // Sticky flag: set on the increment that wraps AddrA back to zero
    always_comb begin
        ovf_a_d = ovf_a_q | (IncA & (addr_a_q == ADDR_A_LAST));
    end

    // Overflow register, cleared only by reset
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            ovf_a_q <= 1'b0;
        end else begin
            ovf_a_q <= ovf_a_d;
        end
    end

    assign OvfA = ovf_a_q;
`endif

    assign AddrA  = addr_a_q;
    assign AddrB  = addr_b_q;
    assign DOutA  = dout_a_q;
    assign DOutB  = dout_b_q;
    assign WrCntB = wr_cnt_b_q;

endmodule
`default_nettype wire

// File: doc/transfer_datapath.md
TRANSFER_DATAPATH -- requirements
Module: transfer_datapath

Interface
REQ-001 Parameter DW, default 8, data word width in bits.
REQ-002 Parameter AWA, default 3, memory A address width; depth 2**AWA (8 words).
REQ-003 Parameter AWB, default 2, memory B address width; depth 2**AWB (4 words).
REQ-004 Port clock, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port Reset, input, 1, asynchronous active-high reset.
REQ-006 Port IncA, input, 1, advance memory A address counter.
REQ-007 Port IncB, input, 1, advance memory B address counter.
REQ-008 Port WEA, input, 1, write enable for memory A.
REQ-009 Port WEB, input, 1, write enable for memory B.
REQ-010 Port DataIn, input, DW, external write data for memory A.
REQ-011 Port AddrA, output, AWA, current memory A address.
REQ-012 Port AddrB, output, AWB, current memory B address.
REQ-013 Port DOutA, output, DW, registered read data of memory A.
REQ-014 Port DOutB, output, DW, registered read data of memory B.
REQ-015 Port WrCntB, output, AWB+1, number of memory B writes since reset, saturating at 2**AWB.

Function
REQ-016 Edge with WEA=1: memA[AddrA] <= DataIn, using the address held before that edge.
REQ-017 Edge with IncA=1: AddrA <= AddrA+1 modulo 2**AWA; 7 wraps to 0.
REQ-018 WEA=1 and IncA=1 on the same edge: write to the old address, then advance; no conflict.
REQ-019 Every edge: DOutA <= memA[AddrA] (old address); one-cycle read latency.
REQ-020 Read/write collision on memory A (WEA=1, same address): DOutA takes DataIn (write-first).
REQ-021 Edge with WEB=1: memB[AddrB] <= DOutA as held before that edge; this is the A-to-B transfer path.
REQ-022 Edge with IncB=1: AddrB <= AddrB+1 modulo 2**AWB; 3 wraps to 0.
REQ-023 Every edge: DOutB <= memB[AddrB] (old address); collision with WEB=1 at the same address returns the new data (write-first).
REQ-024 Edge with WEB=1: WrCntB increments by 1 unless already 2**AWB; it holds at 2**AWB thereafter.
REQ-025 Inc/WE inputs at 0: the corresponding address, memory and counter hold their values.
REQ-026 Any combination of IncA, IncB, WEA and WEB may be asserted on the same edge; each acts independently per REQ-016..024.

Reset
REQ-027 Reset=1 immediately forces AddrA=0, AddrB=0, DOutA=0, DOutB=0 and WrCntB=0, without waiting for clock.
REQ-028 Reset=1 clears every memory A and memory B word to 0.
REQ-029 While Reset=1, all Inc/WE inputs are ignored.
REQ-030 Reset asserted mid-transfer abandons the transfer; no partial write survives.
REQ-031 The first active edge after Reset deasserts behaves per REQ-016..026.

Configuration
REQ-032 Macro XFER_OVF_EN, when defined, adds output OvfA (1 bit).
REQ-033 With XFER_OVF_EN, OvfA is sticky: it sets when IncA wraps AddrA from 2**AWA-1 to 0.
REQ-034 With XFER_OVF_EN, OvfA clears only on Reset.
REQ-035 Without XFER_OVF_EN, port OvfA and its register do not exist; all other behaviour is identical.

Verification
REQ-036 Reset, then 8 edges with WEA=IncA=1 and DataIn=8'h10..8'h17 -> memA[0..7]=10..17; AddrA=0 after wrap; OvfA=1 if XFER_OVF_EN.
REQ-037 After REQ-036, one edge with IncA=1 -> next edge gives DOutA=8'h11; AddrA=2.
REQ-038 DOutA=8'h15, WEB=1, AddrB=3, then IncB=1 -> memB[3]=8'h15; AddrB wraps to 0; WrCntB increments.
REQ-039 6 edges with WEB=1 -> WrCntB=4 (saturated), never 5 or 0.
REQ-040 WEA=1, AddrA=2, DataIn=8'hAA -> DOutA=8'hAA next edge (write-first).
REQ-041 Reset pulsed between edges mid-transfer -> all outputs 0 immediately; readback of memA and memB returns all 0.
